// File: rtl/controle_fila_pkg.sv
// Shared types and constants for the queue sequencer/arbiter.
package controle_fila_pkg;

  // Depth of the downstream fila FIFO; the sequencer's occupancy count tracks it.
  localparam int PROFUNDIDADE_FILA = 8;

  // Sequencer states: idle/arbitrate, enqueue strobe, dequeue latch, queue shift, deliver.
  typedef enum logic [2:0] {
    OCIOSO,
    ENFILEIRA,
    DESENFILEIRA,
    ESPERA,
    ENTREGA
  } estado_t;

  // Requesters, listed in round-robin order (CONS wraps back to PROD0).
  typedef enum logic [1:0] {
    PROD0,
    PROD1,
    CONS
  } solicitante_t;

endpackage

// File: rtl/arbitro_rr.sv
// Three-way round-robin arbiter. The search starts at the requester after
// the last granted one. The output is combinational, and the pointer is held
// by the caller.
module arbitro_rr
  import controle_fila_pkg::*;
(
  input  logic [2:0]   req,       // bit 0 prod0, bit 1 prod1, bit 2 cons
  input  logic [2:0]   elegivel,  // same bit order; masks requests the queue cannot serve
  input  solicitante_t ultimo,    // last requester that received a grant
  output logic [2:0]   grant      // one-hot, all zero when no candidate
);

  logic [2:0] cand;

  // Priority walk rotated by the last grant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant = 3'b000;
    cand  = req & elegivel;
    case (ultimo)
      PROD0: begin
        if      (cand[1]) grant = 3'b010;
        else if (cand[2]) grant = 3'b100;
        else if (cand[0]) grant = 3'b001;
      end
      PROD1: begin
        if      (cand[2]) grant = 3'b100;
        else if (cand[0]) grant = 3'b001;
        else if (cand[1]) grant = 3'b010;
      end
      default: begin
        if      (cand[0]) grant = 3'b001;
        else if (cand[1]) grant = 3'b010;
        else if (cand[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/controle_fila.sv
// Sequencer in front of the fila FIFO. It shares the queue between two
// producers and one consumer. It issues single-cycle enqueue/dequeue strobes
// that honour the queue's latch-then-shift dequeue, and it keeps its own
// occupancy count so the queue is never over- or under-run.
module controle_fila
  import controle_fila_pkg::*;
#(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = PROFUNDIDADE_FILA
) (
  input  logic               clk_10KHz,
  input  logic               reset,
  input  logic               prod0_req,
  input  logic [LARGURA-1:0] prod0_dado,
  output logic               prod0_ack,
  input  logic               prod1_req,
  input  logic [LARGURA-1:0] prod1_dado,
  output logic               prod1_ack,
  input  logic               cons_req,
  output logic               cons_ack,
  output logic [LARGURA-1:0] cons_dado,
  output logic               fila_enqueue,
  output logic               fila_dequeue,
  output logic [LARGURA-1:0] fila_dado_in,
  input  logic [LARGURA-1:0] fila_dado_out,
  output logic [3:0]         ocupacao,
  output logic               cheio,
  output logic               vazio
);

  estado_t            estado_q,    estado_d;
  solicitante_t       ultimo_q,    ultimo_d;     // round-robin pointer
  solicitante_t       alvo_q,      alvo_d;       // producer being served in ENFILEIRA
  logic [3:0]         ocupacao_q,  ocupacao_d;
  logic [LARGURA-1:0] cons_dado_q, cons_dado_d;

  logic [2:0] req_vec;
  logic [2:0] elegivel;
  logic [2:0] grant;

  // Full/empty flags come straight from the local occupancy count.
  assign cheio     = (ocupacao_q == 4'(PROFUNDIDADE));
  assign vazio     = (ocupacao_q == 4'd0);
  assign ocupacao  = ocupacao_q;
  assign cons_dado = cons_dado_q;

  // Producers may only win while there is room, and the consumer only while data exists.
  assign req_vec  = {cons_req, prod1_req, prod0_req};
  assign elegivel = {~vazio, ~cheio, ~cheio};

  arbitro_rr u_arbitro (
    .req      (req_vec),
    .elegivel (elegivel),
    .ultimo   (ultimo_q),
    .grant    (grant)
  );

  // Next-state logic and strobes decoded from the current state.
  always_comb begin
    estado_d     = estado_q;
    ultimo_d     = ultimo_q;
    alvo_d       = alvo_q;
    ocupacao_d   = ocupacao_q;
    cons_dado_d  = cons_dado_q;
    prod0_ack    = 1'b0;
    prod1_ack    = 1'b0;
    cons_ack     = 1'b0;
    fila_enqueue = 1'b0;
    fila_dequeue = 1'b0;
    fila_dado_in = '0;

    case (estado_q)
      OCIOSO: begin
        if (grant[0]) begin
          estado_d = ENFILEIRA;
          alvo_d   = PROD0;
          ultimo_d = PROD0;
        end else if (grant[1]) begin
          estado_d = ENFILEIRA;
          alvo_d   = PROD1;
          ultimo_d = PROD1;
        end else if (grant[2]) begin
          estado_d = DESENFILEIRA;
          ultimo_d = CONS;
        end
      end

      ENFILEIRA: begin
        fila_enqueue = 1'b1;
        if (alvo_q == PROD1) begin
          prod1_ack    = 1'b1;
          fila_dado_in = prod1_dado;
        end else begin
          prod0_ack    = 1'b1;
          fila_dado_in = prod0_dado;
        end
        ocupacao_d = ocupacao_q + 4'd1;
        estado_d   = OCIOSO;
      end

      DESENFILEIRA: begin
        // The queue latches its head on this strobe and shifts on the following cycle.
        fila_dequeue = 1'b1;
        estado_d     = ESPERA;
      end

      ESPERA: begin
        // The queue is shifting, so no strobe is issued. Its latched head is stable on fila_dado_out.
        cons_dado_d = fila_dado_out;
        ocupacao_d  = ocupacao_q - 4'd1;
        estado_d    = ENTREGA;
      end

      ENTREGA: begin
        cons_ack = 1'b1;
        estado_d = OCIOSO;
      end

      default: estado_d = OCIOSO;
    endcase
  end

  // State registers with synchronous reset shared with the fila FIFO.
  always_ff @(posedge clk_10KHz) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: every register here is control or a visible output, so each one gets a reset value.
      estado_q    <= OCIOSO;
      ultimo_q    <= CONS;
      alvo_q      <= PROD0;
      ocupacao_q  <= 4'd0;
      cons_dado_q <= '0;
    end else begin
      estado_q    <= estado_d;
      ultimo_q    <= ultimo_d;
      alvo_q      <= alvo_d;
      ocupacao_q  <= ocupacao_d;
      cons_dado_q <= cons_dado_d;
    end
  end

endmodule

// File: tb/tb_controle_fila.sv
// Directed bench for controle_fila with a small behavioural model of the fila FIFO.
module tb_controle_fila;
  import controle_fila_pkg::*;

  localparam int LARGURA = 8;

  logic               clk_10KHz = 1'b0;
  logic               reset;
  logic               prod0_req, prod1_req, cons_req;
  logic [LARGURA-1:0] prod0_dado, prod1_dado;
  logic               prod0_ack, prod1_ack, cons_ack;
  logic [LARGURA-1:0] cons_dado;
  logic               fila_enqueue, fila_dequeue;
  logic [LARGURA-1:0] fila_dado_in, fila_dado_out;
  logic [3:0]         ocupacao;
  logic               cheio, vazio;

  int checks = 0;
  int errors = 0;

  controle_fila #(.LARGURA(LARGURA), .PROFUNDIDADE(PROFUNDIDADE_FILA)) dut (
    .clk_10KHz     (clk_10KHz),
    .reset         (reset),
    .prod0_req     (prod0_req),
    .prod0_dado    (prod0_dado),
    .prod0_ack     (prod0_ack),
    .prod1_req     (prod1_req),
    .prod1_dado    (prod1_dado),
    .prod1_ack     (prod1_ack),
    .cons_req      (cons_req),
    .cons_ack      (cons_ack),
    .cons_dado     (cons_dado),
    .fila_enqueue  (fila_enqueue),
    .fila_dequeue  (fila_dequeue),
    .fila_dado_in  (fila_dado_in),
    .fila_dado_out (fila_dado_out),
    .ocupacao      (ocupacao),
    .cheio         (cheio),
    .vazio         (vazio)
  );

  always #50 clk_10KHz = ~clk_10KHz;

  // fila model: the dequeue strobe latches the head to data_out, and the next edge shifts it out.
  logic [LARGURA-1:0] fila_m[$];
  logic [LARGURA-1:0] saida_m;
  logic               desloca_m;
  assign fila_dado_out = saida_m;

  always @(posedge clk_10KHz) begin
    if (reset) begin
      fila_m.delete();
      saida_m   <= '0;
      desloca_m <= 1'b0;
    end else begin
      if (desloca_m && fila_m.size() > 0) void'(fila_m.pop_front());
      if (fila_enqueue) fila_m.push_back(fila_dado_in);
      if (fila_dequeue && fila_m.size() > 0) saida_m <= fila_m[0];
      desloca_m <= fila_dequeue;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_10KHz);
  endtask

  task automatic aplica_reset();
    reset      = 1'b1;
    prod0_req  = 1'b0;
    prod1_req  = 1'b0;
    cons_req   = 1'b0;
    prod0_dado = '0;
    prod1_dado = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // One producer transaction; it returns at the negedge of the following OCIOSO cycle.
  task automatic enfileira(input int p, input logic [LARGURA-1:0] d, input string tag);
    bit ok = 0;
    if (p == 0) begin prod0_req = 1'b1; prod0_dado = d; end
    else        begin prod1_req = 1'b1; prod1_dado = d; end
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      if ((p == 0 && prod0_ack) || (p == 1 && prod1_ack)) begin
        ok = 1;
        check({tag, "_dado"}, 32'(fila_dado_in), 32'(d));
        if (p == 0) prod0_req = 1'b0; else prod1_req = 1'b0;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  // One consumer transaction; it checks the delivered byte on the cons_ack cycle.
  task automatic desenfileira(input logic [LARGURA-1:0] esperado, input string tag);
    bit ok = 0;
    cons_req = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      tick();
      if (cons_ack) begin
        ok = 1;
        check(tag, 32'(cons_dado), 32'(esperado));
        cons_req = 1'b0;
      end
    end
    if (!ok) check({tag, "_timeout"}, 32'd0, 32'd1);
    tick();
  endtask

  // Wait for the next grant: 0/1 on a producer ack, 2 on a dequeue strobe, and -1 on timeout.
  task automatic espera_concessao(input string tag, output int quem);
    quem = -1;
    for (int n = 0; n < 20 && quem < 0; n++) begin
      tick();
      if (prod0_ack)         quem = 0;
      else if (prod1_ack)    quem = 1;
      else if (fila_dequeue) quem = 2;
    end
    if (quem < 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int quem;
    int cnt;
    int ordem2[4]  = '{0, 1, 0, 1};
    int ordem6[6]  = '{0, 1, 2, 0, 1, 2};
    logic [7:0] saida6[2] = '{8'h22, 8'h23};
    logic [7:0] dreno[6]  = '{8'h24, 8'h25, 8'h31, 8'h41, 8'h31, 8'h41};

    // Reset state, followed by a single enqueue of 0x11 from prod0.
    aplica_reset();
    check("rst_ocupacao", 32'(ocupacao), 32'd0);
    check("rst_vazio", 32'(vazio), 32'd1);
    check("rst_cheio", 32'(cheio), 32'd0);
    check("rst_cons_dado", 32'(cons_dado), 32'd0);
    check("rst_strobes", 32'({prod0_ack, prod1_ack, cons_ack, fila_enqueue, fila_dequeue}), 32'd0);
    prod0_req = 1'b1; prod0_dado = 8'h11;
    tick();
    check("p0_ack_latency", 32'(prod0_ack), 32'd1);
    check("p0_enqueue", 32'(fila_enqueue), 32'd1);
    check("p0_dado_in", 32'(fila_dado_in), 32'h11);
    check("p0_ocup_before", 32'(ocupacao), 32'd0);
    prod0_req = 1'b0;
    tick();
    check("p0_ack_pulse", 32'(prod0_ack), 32'd0);
    check("p0_ocupacao", 32'(ocupacao), 32'd1);
    check("p0_vazio", 32'(vazio), 32'd0);

    // Two producers holding their requests should alternate grants.
    aplica_reset();
    prod0_req = 1'b1; prod0_dado = 8'hA0;
    prod1_req = 1'b1; prod1_dado = 8'hB0;
    for (int i = 0; i < 4; i++) begin
      espera_concessao("alt", quem);
      check($sformatf("alt_grant%0d", i), 32'(quem), 32'(ordem2[i]));
      check($sformatf("alt_dado%0d", i), 32'(fila_dado_in), (ordem2[i] == 0) ? 32'hA0 : 32'hB0);
      if (i == 3) begin prod0_req = 1'b0; prod1_req = 1'b0; end
    end
    tick();
    check("alt_ocupacao", 32'(ocupacao), 32'd4);

    // Fill the queue to full, then confirm that producers are locked out and the consumer drains in order.
    aplica_reset();
    for (int i = 1; i <= 8; i++) enfileira(0, 8'(i), $sformatf("fill%0d", i));
    check("full_ocupacao", 32'(ocupacao), 32'd8);
    check("full_cheio", 32'(cheio), 32'd1);
    prod0_req = 1'b1; prod1_req = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      if (prod0_ack || prod1_ack || fila_enqueue) cnt++;
    end
    check("full_no_ack", 32'(cnt), 32'd0);
    prod0_req = 1'b0; prod1_req = 1'b0;
    desenfileira(8'h01, "full_drain");
    check("full_drain_ocup", 32'(ocupacao), 32'd7);
    check("full_drain_cheio", 32'(cheio), 32'd0);

    // An empty queue must ignore the consumer until prod1 supplies 0x55.
    aplica_reset();
    cons_req = 1'b1;
    cnt = 0;
    repeat (6) begin
      tick();
      if (fila_dequeue || cons_ack) cnt++;
    end
    check("empty_no_deq", 32'(cnt), 32'd0);
    enfileira(1, 8'h55, "empty_p1");
    cnt = -1;
    for (int n = 0; n < 10 && cnt < 0; n++) begin
      tick();
      if (fila_dequeue) cnt = 0;
    end
    if (cnt < 0) check("empty_deq_timeout", 32'd0, 32'd1);
    else begin
      while (!cons_ack && cnt < 10) begin tick(); cnt++; end
      check("empty_ack_latency", 32'(cnt), 32'd2);
      check("empty_cons_dado", 32'(cons_dado), 32'h55);
      check("empty_ocupacao", 32'(ocupacao), 32'd0);
    end
    cons_req = 1'b0;
    tick();

    // All three requesters on a half-full queue: the pointer starts at CONS, so the order is prod0, prod1, cons.
    aplica_reset();
    for (int i = 0; i < 5; i++) enfileira(0, 8'(8'h21 + i), $sformatf("half%0d", i));
    desenfileira(8'h21, "half_pre");
    prod0_req = 1'b1; prod0_dado = 8'h31;
    prod1_req = 1'b1; prod1_dado = 8'h41;
    cons_req  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      espera_concessao("rr", quem);
      check($sformatf("rr_grant%0d", i), 32'(quem), 32'(ordem6[i]));
      if (i == 5) begin prod0_req = 1'b0; prod1_req = 1'b0; cons_req = 1'b0; end
      if (quem == 2) begin
        repeat (2) tick();
        check($sformatf("rr_ack%0d", i), 32'(cons_ack), 32'd1);
        check($sformatf("rr_cons%0d", i), 32'(cons_dado), 32'(saida6[i / 3]));
      end
    end
    tick();
    check("rr_ocupacao", 32'(ocupacao), 32'd6);
    for (int i = 0; i < 6; i++) desenfileira(dreno[i], $sformatf("drain%0d", i));
    check("drain_vazio", 32'(vazio), 32'd1);

    // Reset asserted while the queue is shifting (ESPERA) must abort delivery.
    aplica_reset();
    enfileira(0, 8'h77, "abort_fill");
    cons_req = 1'b1;
    cnt = -1;
    for (int n = 0; n < 10 && cnt < 0; n++) begin
      tick();
      if (fila_dequeue) cnt = 0;
    end
    if (cnt < 0) check("abort_deq_timeout", 32'd0, 32'd1);
    tick();                       // ESPERA cycle
    reset = 1'b1; cons_req = 1'b0;
    tick();
    check("abort_ack", 32'(cons_ack), 32'd0);
    check("abort_ocupacao", 32'(ocupacao), 32'd0);
    check("abort_cons_dado", 32'(cons_dado), 32'd0);
    check("abort_strobes", 32'({fila_enqueue, fila_dequeue}), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      tick();
      if (cons_ack) cnt++;
    end
    check("abort_no_late_ack", 32'(cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_fila.md
# controle_fila

Sequencer and arbiter sitting in front of the 8-entry `fila` FIFO. It shares the queue between two producers and one consumer with round-robin fairness. It issues single-cycle `enqueue_in`/`dequeue_in` pulses that respect the queue's two-cycle dequeue (latch, then shift), and it keeps its own occupancy count so it never over- or under-runs the queue. It also returns dequeued bytes to the consumer with a valid pulse.

## Interface
Parameters:
- `LARGURA`, 8, data width in bits.
- `PROFUNDIDADE`, 8, queue depth; must match `fila`.

Ports:
- `clk_10KHz`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `prod0_req`, `prod1_req`  in  1 each  producer enqueue request; level, held until ack.
- `prod0_dado`, `prod1_dado`  in  LARGURA each  producer data; stable while req high.
- `prod0_ack`, `prod1_ack`  out  1 each  one-cycle pulse, data accepted.
- `cons_req`  in  1  consumer dequeue request; level, held until ack.
- `cons_ack`  out  1  one-cycle pulse, `cons_dado` valid.
- `cons_dado`  out  LARGURA  last dequeued byte; held until next delivery.
- `fila_enqueue`  out  1  to `fila.enqueue_in`.
- `fila_dequeue`  out  1  to `fila.dequeue_in`.
- `fila_dado_in`  out  LARGURA  to `fila.data_in`.
- `fila_dado_out`  in  LARGURA  from `fila.data_out`.
- `ocupacao`  out  4  entries currently stored, 0..8.
- `cheio`  out  1  `ocupacao` == PROFUNDIDADE.
- `vazio`  out  1  `ocupacao` == 0.

## Operation
- FSM states: OCIOSO, ENFILEIRA, DESENFILEIRA, ESPERA, ENTREGA.
- Arbitration happens only in OCIOSO.
  - Candidates are prod0 (eligible if `prod0_req` and not `cheio`), prod1 (same rule) and cons (eligible if `cons_req` and not `vazio`).
  - Round-robin: search starts at the requester after the last granted one. The order is prod0 → prod1 → cons → prod0.
  - The pointer updates only on a grant.
- Grant to producer: go to ENFILEIRA.
  - `fila_enqueue`=1, `fila_dado_in` = granted producer's data, granted `prodX_ack`=1.
  - `ocupacao` increments at the end of the cycle, then return to OCIOSO.
- Grant to consumer: go to DESENFILEIRA, `fila_dequeue`=1.
- DESENFILEIRA → ESPERA.
  - In ESPERA the queue is shifting, so no enqueue or dequeue is issued.
  - `cons_dado` <= `fila_dado_out` and `ocupacao` decrements, both at the end of ESPERA.
- ESPERA → ENTREGA: `cons_ack`=1 for one cycle, then OCIOSO.
- No eligible request: stay in OCIOSO with all strobes 0.
- A request dropped before grant is simply not served. A request dropped mid-transaction does not abort it; the transaction completes.
- Enqueue when `cheio` is never issued, and dequeue when `vazio` is never issued. A full queue with a waiting consumer drains normally.
- `ocupacao` arithmetic is 4-bit unsigned and can never leave the range 0..8 by construction.

## Timing
- Reset values: state OCIOSO, all acks and strobes 0, `cons_dado`=0, `ocupacao`=0, `vazio`=1, `cheio`=0, RR pointer = cons (so prod0 has first priority).
- `fila` shares the same `reset`, so both clear on the same edge.
- Strobes and acks decode directly from state.
- Enqueue latency:
  - Request seen high in an OCIOSO cycle gives ack and `fila_enqueue` in the next cycle.
  - 2 cycles per enqueue; a held request can be re-granted every 2 cycles.
- Dequeue latency: 4 cycles, OCIOSO → DESENFILEIRA → ESPERA → ENTREGA.
  - `cons_ack` comes 3 cycles after the grant decision.
  - `cons_dado` is valid from the ENTREGA cycle onward.
- Simultaneous requests are resolved by RR order only; no starvation (bounded by 3 grants).
- Reset asserted mid-transaction returns to OCIOSO on that edge. Any pending ack is lost and the requester must re-request.

## Structure
- Package `controle_fila_pkg` holds:
  - enum `estado_t` {OCIOSO, ENFILEIRA, DESENFILEIRA, ESPERA, ENTREGA};
  - typedef `solicitante_t` {PROD0, PROD1, CONS};
  - constant `PROFUNDIDADE_FILA` = 8.
- Sub-module `arbitro_rr` is a 3-way round-robin arbiter.
  - Inputs: request vector, eligibility mask, last-grant pointer.
  - Output: one-hot grant, combinational.
  - The pointer register stays in `controle_fila`.
- The top instantiates `controle_fila` beside `fila` and wires the strobes directly.

## Test plan
- Reset, then prod0 sends 0x11: `prod0_ack` pulses 1 cycle after request, `fila_enqueue` shows 0x11, `ocupacao`=1, `vazio`=0.
- prod0 and prod1 hold requests (0xA0, 0xB0) together: grants alternate prod0, prod1, prod0. After 4 enqueues, `ocupacao`=4.
- Fill with 0x01..0x08: `cheio`=1. Further producer requests get no ack. `cons_req` then yields `cons_ack` with `cons_dado`=0x01 and `ocupacao`=7.
- Empty queue with `cons_req` high: no `fila_dequeue` and no ack. prod1 enqueues 0x55, then the consumer receives 0x55 exactly 3 cycles after its grant.
- All three requesting on a half-full queue: grant order follows RR (prod0, prod1, cons, ...) and no requester waits more than 3 grants. Queue content order is preserved.
- Reset asserted during ESPERA: next cycle is OCIOSO, no `cons_ack`, `ocupacao`=0, `cons_dado`=0.
